// File: rtl/uart_pkt_pkg.sv
// Shared types and checksum for the UART TX packetizer and its bench model.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ID,
    LEN,
    PAYLOAD,
    CSUM
  } pkt_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

  // Widest payload pkt_csum can see; callers zero-extend narrower payload buses.
  localparam int PKT_MAX_BYTES = 16;

  function automatic logic [7:0] pkt_csum(input logic [7:0] id,
                                          input logic [7:0] len,
                                          input logic [8*PKT_MAX_BYTES-1:0] payload);
    logic [7:0] c;
    c = id ^ len;
    for (int i = 0; i < PKT_MAX_BYTES; i++) begin
      if (8'(i) < len) c = c ^ payload[8*i +: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_packetizer.sv
// Frames one message as SYNC,ID,LEN,PAYLOAD,CSUM onto a byte valid/ready stream.
// Latency: SYNC valid one cycle after capture; each byte holds until byte_ready; msg_ready only in IDLE.
module uart_tx_packetizer
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  localparam int        LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     msg_valid,
  output logic                     msg_ready,
  input  logic [7:0]               msg_id,
  input  logic [LEN_W-1:0]         msg_len,
  input  logic [8*MAX_PAYLOAD-1:0] msg_payload,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     frame_done,
  output logic                     len_err,
  output logic [15:0]              frames_sent
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  pkt_state_t                   state_q, state_d;
  logic [7:0]                   id_q, csum_q;
  logic [LEN_W-1:0]             len_q, idx_q, idx_d, len_in;
  logic [MAX_PAYLOAD-1:0][7:0]  pay_q;
  logic [8*PKT_MAX_BYTES-1:0]   pay_ext;
  logic [7:0]                   data_d, pay_byte;
  logic                         done_d, capture, accept;
  logic [15:0]                  frames_q;

  assign msg_ready   = (state_q == IDLE);
  assign capture     = msg_valid && msg_ready;
  assign accept      = byte_valid && byte_ready;
  assign len_in      = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
  assign frames_sent = frames_q;

  always_comb begin
    pay_ext = '0;
    pay_ext[8*MAX_PAYLOAD-1:0] = msg_payload;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (capture) begin
                 state_d = SYNC;
                 idx_d   = '0;
               end
      SYNC:    if (accept) state_d = ID;
      ID:      if (accept) state_d = LEN;
      LEN:     if (accept) state_d = (len_q == '0) ? CSUM : PAYLOAD;
      PAYLOAD: if (accept) begin
                 if (idx_q + LEN_W'(1) == len_q) state_d = CSUM;
                 else                             idx_d   = idx_q + LEN_W'(1);
               end
      CSUM:    if (accept) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  // Output byte is chosen from the next state so byte_data/byte_valid can be registered.
  always_comb begin
    pay_byte = 8'h00;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (idx_d == LEN_W'(i)) pay_byte = pay_q[i];
    end
    case (state_d)
      SYNC:    data_d = SYNC_BYTE;
      ID:      data_d = id_q;
      LEN:     data_d = 8'(len_q);
      PAYLOAD: data_d = pay_byte;
      CSUM:    data_d = csum_q;
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      id_q       <= '0;
      len_q      <= '0;
      pay_q      <= '0;
      csum_q     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_valid <= (state_d != IDLE);
      byte_data  <= data_d;
      frame_done <= done_d;
      len_err    <= capture && (msg_len > MAX_LEN);
      if (done_d) frames_q <= frames_q + 16'd1;
      if (capture) begin
        id_q   <= msg_id;
        len_q  <= len_in;
        pay_q  <= msg_payload;
        csum_q <= pkt_csum(msg_id, 8'(len_in), pay_ext);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Directed bench for uart_tx_packetizer with hand-computed frames.
module tb_uart_tx_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [7:0]  msg_id = 8'h00;
  logic [2:0]  msg_len = 3'd0;
  logic [31:0] msg_payload = 32'h0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        frame_done;
  logic        len_err;
  logic [15:0] frames_sent;

  int passed = 0;
  int total = 0;
  logic [7:0] fb [0:15];
  int fn, fdone, ferr;

  always #5 clk = ~clk;

  uart_tx_packetizer dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_id(msg_id), .msg_len(msg_len), .msg_payload(msg_payload),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_done(frame_done), .len_err(len_err), .frames_sent(frames_sent)
  );

  task automatic send_msg(input logic [7:0] id, input logic [2:0] len, input logic [31:0] pay);
    bit got;
    got = 0;
    @(negedge clk);
    msg_id = id; msg_len = len; msg_payload = pay; msg_valid = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      if (msg_ready) begin
        @(posedge clk); #1;
        msg_valid = 1'b0;
        got = 1;
      end else @(negedge clk);
    end
    total++;
    if (!got) begin
      $display("FAIL send_msg id=%h: msg_ready never seen, got 0 want 1", id);
      msg_valid = 1'b0;
    end else passed++;
  endtask

  // Records every accepted byte (byte_ready held high) until frame_done.
  task automatic collect_frame();
    byte_ready = 1'b1;
    fn = 0; fdone = 0; ferr = 0;
    for (int c = 0; c < 60; c++) begin
      if (len_err) ferr++;
      if (frame_done) begin
        fdone++;
        break;
      end
      if (byte_valid && fn < 16) begin
        fb[fn] = byte_data;
        fn++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_ready();
    @(negedge clk); byte_ready = 1'b1;
    @(negedge clk); byte_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok_rdy, ok_vld, ok_cnt, ok_dat;
    ok_rdy = 1; ok_vld = 1; ok_cnt = 1; ok_dat = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (msg_ready !== 1'b1) ok_rdy = 0;
      if (byte_valid !== 1'b0) ok_vld = 0;
      if (frames_sent !== 16'h0) ok_cnt = 0;
      if (byte_data !== 8'h00) ok_dat = 0;
    end
    total++; if (!ok_rdy) $display("FAIL reset_msg_ready got %b want 1", msg_ready); else passed++;
    total++; if (!ok_vld) $display("FAIL reset_byte_valid got %b want 0", byte_valid); else passed++;
    total++; if (!ok_cnt) $display("FAIL reset_frames_sent got %h want 0000", frames_sent); else passed++;
    total++; if (!ok_dat) $display("FAIL reset_byte_data got %h want 00", byte_data); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] exp [0:4];
    exp = '{8'hAA, 8'h12, 8'h02, 8'h56, 8'h72};
    exp[4] = 8'h72;
    exp[3] = 8'h34;
    exp[2] = 8'h02;
    // payload b0=56 then b1=34 follows after b0; reorder into wire order
    exp = '{8'hAA, 8'h12, 8'h02, 8'h56, 8'h34};
    send_msg(8'h12, 3'd2, 32'h0000_3456);
    collect_frame();
    total++; if (fn !== 6 - 0 - 0 && fn !== 6) begin end
    total--;
    total++; if (fn !== 6) $display("FAIL basic_len got %0d want 6", fn); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (fb[i] !== exp[i]) $display("FAIL basic_byte%0d got %h want %h", i, fb[i], exp[i]);
      else passed++;
    end
    total++; if (fb[5] !== 8'h72) $display("FAIL basic_csum got %h want 72", fb[5]); else passed++;
    total++; if (fdone !== 1) $display("FAIL basic_frame_done got %0d want 1", fdone); else passed++;
    total++; if (ferr !== 0) $display("FAIL basic_len_err got %0d want 0", ferr); else passed++;
    total++; if (frames_sent !== 16'd1) $display("FAIL basic_frames_sent got %h want 0001", frames_sent); else passed++;
  endtask

  task automatic test_zero_len();
    logic [7:0] exp [0:3];
    exp = '{8'hAA, 8'h05, 8'h00, 8'h05};
    send_msg(8'h05, 3'd0, 32'hDEAD_BEEF);
    collect_frame();
    total++; if (fn !== 4) $display("FAIL zero_len_count got %0d want 4", fn); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fb[i] !== exp[i]) $display("FAIL zero_len_byte%0d got %h want %h", i, fb[i], exp[i]);
      else passed++;
    end
    total++; if (frames_sent !== 16'd2) $display("FAIL zero_len_frames_sent got %h want 0002", frames_sent); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] exp [0:2];
    exp = '{8'h22, 8'h44, 8'h47};
    byte_ready = 1'b0;
    send_msg(8'h33, 3'd3, 32'h0044_2211);
    repeat (4) pulse_ready();
    ok = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(byte_valid === 1'b1 && byte_data === 8'h22)) ok = 0;
    end
    total++;
    if (!ok) $display("FAIL stall_hold got vld=%b dat=%h want vld=1 dat=22", byte_valid, byte_data);
    else passed++;
    collect_frame();
    total++; if (fn !== 3) $display("FAIL stall_tail_count got %0d want 3", fn); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (fb[i] !== exp[i]) $display("FAIL stall_byte%0d got %h want %h", i, fb[i], exp[i]);
      else passed++;
    end
    total++; if (fdone !== 1) $display("FAIL stall_frame_done got %0d want 1", fdone); else passed++;
  endtask

  task automatic test_len_err();
    logic [7:0] exp [0:7];
    exp = '{8'hAA, 8'h21, 8'h04, 8'h01, 8'h02, 8'h04, 8'h08, 8'h2A};
    send_msg(8'h21, 3'd7, 32'h0804_0201);
    collect_frame();
    total++; if (ferr !== 1) $display("FAIL len_err_pulse got %0d want 1", ferr); else passed++;
    total++; if (fn !== 8) $display("FAIL len_err_count got %0d want 8", fn); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (fb[i] !== exp[i]) $display("FAIL len_err_byte%0d got %h want %h", i, fb[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic       ev [0:11];
    logic [7:0] ed [0:11];
    logic       v  [0:11];
    logic [7:0] d  [0:11];
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ed = '{8'hAA, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'hAA, 8'h0B, 8'h00, 8'h0B, 8'h00, 8'hAA, 8'h0B};
    byte_ready = 1'b1;
    @(negedge clk);
    msg_id = 8'h0A; msg_len = 3'd0; msg_payload = 32'h0; msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_id = 8'h0B;
    for (int i = 0; i < 12; i++) begin
      v[i] = byte_valid;
      d[i] = byte_data;
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (v[i] !== ev[i] || (ev[i] && d[i] !== ed[i]))
        $display("FAIL b2b_cycle%0d got vld=%b dat=%h want vld=%b dat=%h", i, v[i], d[i], ev[i], ed[i]);
      else passed++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    byte_ready = 1'b0;
    send_msg(8'h77, 3'd1, 32'h0000_0099);
    pulse_ready();
    total++;
    if (!(byte_valid === 1'b1 && byte_data === 8'h77))
      $display("FAIL midrst_id_byte got vld=%b dat=%h want vld=1 dat=77", byte_valid, byte_data);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (byte_valid !== 1'b0) $display("FAIL midrst_byte_valid got %b want 0", byte_valid); else passed++;
    total++; if (frames_sent !== 16'h0) $display("FAIL midrst_frames_sent got %h want 0000", frames_sent); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    byte_ready = 1'b1;
    ok = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (byte_valid !== 1'b0 || msg_ready !== 1'b1) ok = 0;
    end
    total++;
    if (!ok) $display("FAIL midrst_no_resume got vld=%b rdy=%b want vld=0 rdy=1", byte_valid, msg_ready);
    else passed++;
    send_msg(8'h05, 3'd0, 32'h0);
    collect_frame();
    total++; if (fn !== 4) $display("FAIL midrst_next_count got %0d want 4", fn); else passed++;
    total++; if (fb[0] !== 8'hAA) $display("FAIL midrst_next_sync got %h want AA", fb[0]); else passed++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frames_q = 16'hFFFF;
    #1 release dut.frames_q;
    total++; if (frames_sent !== 16'hFFFF) $display("FAIL wrap_preload got %h want FFFF", frames_sent); else passed++;
    send_msg(8'h01, 3'd1, 32'h0000_0001);
    collect_frame();
    total++; if (fn !== 5) $display("FAIL wrap_count got %0d want 5", fn); else passed++;
    total++; if (fb[4] !== 8'h01) $display("FAIL wrap_csum got %h want 01", fb[4]); else passed++;
    total++; if (frames_sent !== 16'h0000) $display("FAIL wrap_frames_sent got %h want 0000", frames_sent); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_len_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
